uart_modem_peer: RTL

- DCE-side counterpart of the UART modem-control logic: the modem/peer end of the RS-232 handshake lines.
- Samples the DTE outputs (RTS#, DTR#), which are active low.
- Drives the DTE inputs (CTS#, DSR#, RI#, CD#), which are active low.
- Provides a session FSM, ring-burst generation and CTS hardware flow control with fill-level hysteresis.
- Used as a loopback peer in SoC test harnesses and as a DCE front end next to a receive FIFO.

---
 rtl/uart_modem_peer_pkg.sv | 24 ++
 rtl/uart_modem_peer_if.sv | 13 +
 rtl/uart_sync_sr.sv | 27 ++
 rtl/uart_modem_peer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_modem_peer_pkg.sv
// Shared types and default timing constants for the DCE-side modem peer.
package uart_modem_peer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RING_ON  = 3'd1,
        RING_OFF = 3'd2,
        ARMING   = 3'd3,
        READY    = 3'd4
    } peer_state_e;

    localparam int PeerDsrDelay  = 4;
    localparam int PeerRingOn    = 8;
    localparam int PeerRingOff   = 16;
    localparam int PeerRingCount = 3;

    // Largest of three cycle counts; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_modem_peer_if.sv
// RS-232 modem-control lines between a DTE (master) and the DCE peer (slave).
// All lines are active low.
interface uart_modem_peer_if;
    logic rts_ni;
    logic dtr_ni;
    logic cts_no;
    logic dsr_no;
    logic ri_no;
    logic cd_no;

    modport master (output rts_ni, dtr_ni, input cts_no, dsr_no, ri_no, cd_no);
    modport slave  (input rts_ni, dtr_ni, output cts_no, dsr_no, ri_no, cd_no);
endinterface

// File: rtl/uart_sync_sr.sv
// Multi-stage synchronizer with synchronous reset that presets every stage
// to 1, so an active-low input reads as deasserted straight out of reset.
module uart_sync_sr #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [Stages-1:0] sync_q;
    logic [Stages-1:0] sync_d;

    // Shift the asynchronous input in at the bottom of the chain.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d_i;
    end

    // Synchronizer flops, preset to the deasserted level on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign q_o = sync_q[Stages-1];
endmodule

// File: rtl/uart_modem_peer.sv
// DCE-side modem peer: session FSM (ring bursts, DSR arming, ready session)
// and CTS flow control with fill-level hysteresis. All outputs are registered
// from next-state values so they move on the same edge as the state.
module uart_modem_peer
    import uart_modem_peer_pkg::*;
#(
    parameter int SyncStages    = 2,
    parameter int FillW         = 5,
    parameter int HighWater     = 24,
    parameter int LowWater      = 8,
    parameter int DsrDelay      = PeerDsrDelay,
    parameter int RingOnCycles  = PeerRingOn,
    parameter int RingOffCycles = PeerRingOff,
    parameter int RingCount     = PeerRingCount
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_modem_peer_if.slave modem,
    input  logic             ring_req_i,
    input  logic             carrier_i,
    input  logic [FillW-1:0] fill_level_i,
    output logic [2:0]       state_o,
    output logic             hangup_o,
    output logic             ring_timeout_o
);
    localparam int CntW  = $clog2(max3(DsrDelay, RingOnCycles, RingOffCycles) + 1);
    localparam int RingW = $clog2(RingCount + 1);

    if (LowWater >= HighWater) begin : g_bad_water
        $error("uart_modem_peer: LowWater must be below HighWater");
    end

    logic rts_sync, dtr_sync, rts, dtr;

    uart_sync_sr #(.Stages(SyncStages)) u_sync_rts (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(modem.rts_ni), .q_o(rts_sync)
    );
    uart_sync_sr #(.Stages(SyncStages)) u_sync_dtr (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(modem.dtr_ni), .q_o(dtr_sync)
    );

    assign rts = ~rts_sync;
    assign dtr = ~dtr_sync;

    peer_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RingW-1:0] rings_left_q, rings_left_d;
    logic             throttle_q, throttle_d;
    logic             cts_q, dsr_q, ri_q, cd_q, hangup_q, timeout_q;
    logic             cts_d, dsr_d, ri_d, cd_d, hangup_d, timeout_d;

    // Next-state, counters, hysteresis and registered-output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rings_left_d = rings_left_q;
        hangup_d     = 1'b0;
        timeout_d    = 1'b0;
        throttle_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dtr) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end else if (ring_req_i) begin
                    state_d      = RING_ON;
                    cnt_d        = '0;
                    rings_left_d = RingW'(RingCount);
                end
            end
            RING_ON: begin
                if (dtr) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(RingOnCycles - 1)) begin
                    state_d = RING_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RING_OFF: begin
                if (dtr) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(RingOffCycles - 1)) begin
                    cnt_d        = '0;
                    rings_left_d = rings_left_q - RingW'(1);
                    if (rings_left_q == RingW'(1)) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = RING_ON;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ARMING: begin
                if (!dtr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(DsrDelay - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            READY: begin
                if (!dtr) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    hangup_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Throttle only lives inside a session; between the thresholds it holds.
        if (state_d == READY) begin
            if (int'(fill_level_i) >= HighWater)     throttle_d = 1'b1;
            else if (int'(fill_level_i) <= LowWater) throttle_d = 1'b0;
            else                                     throttle_d = throttle_q;
        end

        ri_d  = (state_d != RING_ON);
        dsr_d = (state_d != READY);
        cd_d  = (state_d == READY) ? ~carrier_i : 1'b1;
        cts_d = (state_d == READY) ? ~(rts & ~throttle_d) : 1'b1;
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rings_left_q <= '0;
            throttle_q   <= 1'b0;
            cts_q        <= 1'b1;
            dsr_q        <= 1'b1;
            ri_q         <= 1'b1;
            cd_q         <= 1'b1;
            hangup_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rings_left_q <= rings_left_d;
            throttle_q   <= throttle_d;
            cts_q        <= cts_d;
            dsr_q        <= dsr_d;
            ri_q         <= ri_d;
            cd_q         <= cd_d;
            hangup_q     <= hangup_d;
            timeout_q    <= timeout_d;
        end
    end

    assign modem.cts_no   = cts_q;
    assign modem.dsr_no   = dsr_q;
    assign modem.ri_no    = ri_q;
    assign modem.cd_no    = cd_q;
    assign state_o        = state_q;
    assign hangup_o       = hangup_q;
    assign ring_timeout_o = timeout_q;
endmodule
